// File: rtl/wb_rr_arbiter_nx1_if.sv
// Wishbone bus bundle used on both sides of wb_rr_arbiter_nx1.
//   NP  : number of ports carried (N masters on the request side, 1 on the slave side)
//   AW  : address width, DW : data width (SEL is DW/8 per port)
// Request fields (cyc/stb/we/adr/dat_w/sel/cti/bte) are packed, port i at [i*W +: W].
// dat_r is a single DW-wide word (broadcast on the master side); ack/err are per port.
// Modports:
//   master : the side issuing cycles (drives requests, receives dat_r/ack/err)
//   slave  : the side answering cycles (receives requests, drives dat_r/ack/err)
interface wb_rr_arbiter_nx1_if #(
  parameter int NP = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NP-1:0]        cyc;
  logic [NP-1:0]        stb;
  logic [NP-1:0]        we;
  logic [NP*AW-1:0]     adr;
  logic [NP*DW-1:0]     dat_w;
  logic [NP*(DW/8)-1:0] sel;
  logic [NP*3-1:0]      cti;
  logic [NP*2-1:0]      bte;
  logic [DW-1:0]        dat_r;
  logic [NP-1:0]        ack;
  logic [NP-1:0]        err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_rr_arbiter_nx1.sv
// Round-robin arbiter sharing one Wishbone slave port between N_MASTERS masters.
// A grant is held for the whole CYC assertion of the winning master, so bursts and
// locked sequences are never split. One dead (IDLE) cycle separates two grants.
//
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   m         : request side bus (interface instance with NP = N_MASTERS), slave modport
//   s         : slave side bus (interface instance with NP = 1), master modport
//   gnt       : registered one-hot grant
//   gnt_id    : index of the granted master, meaningful while |gnt
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall watchdog. If the slave leaves an
// active strobe unanswered for TIMEOUT_CYCLES cycles, the granted master receives a
// one-cycle ERR, the slave cycle is dropped and the arbiter waits in ABORT until that
// master releases CYC. Without the macro a stalled slave holds the grant indefinitely.
module wb_rr_arbiter_nx1 #(
  parameter int N_MASTERS      = 2,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  wb_rr_arbiter_nx1_if.slave   m,
  wb_rr_arbiter_nx1_if.master  s,
  output logic [N_MASTERS-1:0] gnt,
  output logic [IW-1:0]        gnt_id
);
  localparam int N  = N_MASTERS;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t          state, state_d;
  logic [N-1:0]    gnt_d;
  logic [IW-1:0]   gnt_id_d;
  logic [IW-1:0]   last_id, last_id_d;
  logic [IW-1:0]   pick;

  // Signals of the currently granted master
  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat_w;
  logic [SW-1:0]   g_sel;
  logic [2:0]      g_cti;
  logic [1:0]      g_bte;

  logic            tmo_fire;

  // First requester found when scanning from last+1 upward, wrapping past N-1 to 0.
  // Scanning offsets from N down to 1 lets the smallest offset overwrite the result.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] last);
    logic [IW-1:0] c;
    logic [IW-1:0] res;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last) + k) % N);
      if (req[c]) res = c;
    end
    return res;
  endfunction

  assign pick = rr_pick(m.cyc, last_id);

  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_adr   = '0;
    g_dat_w = '0;
    g_sel   = '0;
    g_cti   = '0;
    g_bte   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id == IW'(i)) begin
        g_cyc   = m.cyc[i];
        g_stb   = m.stb[i];
        g_we    = m.we[i];
        g_adr   = m.adr[i*AW +: AW];
        g_dat_w = m.dat_w[i*DW +: DW];
        g_sel   = m.sel[i*SW +: SW];
        g_cti   = m.cti[i*3 +: 3];
        g_bte   = m.bte[i*2 +: 2];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        stall;

  assign stall    = (state == GRANT) && g_cyc && g_stb && !s.ack && !s.err;
  assign tmo_fire = stall && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn || (state_d != state) || s.ack || s.err) begin
      tmo_cnt <= '0;
    end else if (stall) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last_id <= IW'(N - 1);
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      last_id <= last_id_d;
    end
  end

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    last_id_d = last_id;
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.adr     = '0;
    s.dat_w   = '0;
    s.sel     = '0;
    s.cti     = '0;
    s.bte     = '0;
    m.dat_r   = '0;
    m.ack     = '0;
    m.err     = '0;

    case (state)
      IDLE: begin
        // Arbitration looks at CYC only; STB plays no part in priority.
        if (|m.cyc) begin
          state_d   = GRANT;
          gnt_id_d  = pick;
          last_id_d = pick;
          for (int i = 0; i < N; i++) gnt_d[i] = (pick == IW'(i));
        end
      end

      GRANT: begin
        s.cyc   = g_cyc & ~tmo_fire;
        s.stb   = g_stb & ~tmo_fire;
        s.we    = g_we;
        s.adr   = g_adr;
        s.dat_w = g_dat_w;
        s.sel   = g_sel;
        s.cti   = g_cti;
        s.bte   = g_bte;
        m.dat_r = s.dat_r;
        // ACK and ERR are passed unfiltered, even if the slave asserts both.
        for (int i = 0; i < N; i++) begin
          if (gnt_id == IW'(i)) begin
            m.ack[i] = s.ack;
            m.err[i] = s.err | tmo_fire;
          end
        end
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (tmo_fire) begin
          state_d = ABORT;
`endif
        end
      end

`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        // Slave side stays quiet until the aborted master lets go of CYC.
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_wb_rr_arbiter_nx1.sv
// Bench for wb_rr_arbiter_nx1 with two masters: directed stimulus plus a behavioural
// model of the grant rules, compared against the DUT on every falling clock edge.
module tb_wb_rr_arbiter_nx1;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic         clk;
  logic         rstn;
  logic [N-1:0] gnt;
  logic [0:0]   gnt_id;

  int checks   = 0;
  int failures = 0;

  wb_rr_arbiter_nx1_if #(.NP(N), .AW(AW), .DW(DW)) mb ();
  wb_rr_arbiter_nx1_if #(.NP(1), .AW(AW), .DW(DW)) sb ();

  wb_rr_arbiter_nx1 #(
    .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rstn(rstn), .m(mb), .s(sb), .gnt(gnt), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mg: granted master (-1 none), mlast: last granted, mab: aborted, mcnt: stall cycles
  int mg = -1, mlast = N - 1, mcnt = 0;
  bit mab = 1'b0, model_ok = 1'b0;
  int n_g, n_last, n_cnt;
  bit n_ab, stalled, to_now;

  always_comb begin
    stalled = 1'b0;
    to_now  = 1'b0;
    if (mg >= 0 && !mab)
      stalled = mb.cyc[mg] && mb.stb[mg] && !sb.ack[0] && !sb.err[0];
`ifdef WB_ARB_TIMEOUT_EN
    to_now = stalled && (mcnt == T - 1);
`endif
    n_g = mg; n_last = mlast; n_ab = mab; n_cnt = mcnt;
    if (!rstn) begin
      n_g = -1; n_last = N - 1; n_ab = 1'b0; n_cnt = 0;
    end else if (mg < 0) begin
      for (int k = 1; k <= N; k++)
        if (n_g < 0 && mb.cyc[(mlast + k) % N]) n_g = (mlast + k) % N;
      if (n_g >= 0) n_last = n_g;
      n_cnt = 0;
    end else if (!mb.cyc[mg]) begin
      n_g = -1; n_ab = 1'b0; n_cnt = 0;
    end else if (to_now) begin
      n_ab = 1'b1; n_cnt = 0;
    end else if (stalled) begin
      n_cnt = mcnt + 1;
    end else if (sb.ack[0] || sb.err[0]) begin
      n_cnt = 0;
    end
  end

  always @(posedge clk) begin
    mg    <= n_g;
    mlast <= n_last;
    mab   <= n_ab;
    mcnt  <= n_cnt;
    if (!rstn) model_ok <= 1'b1;
  end

  task automatic compare();
    bit            act;
    logic [N-1:0]  e_gnt, e_ack, e_err;
    act   = (mg >= 0) && !mab;
    e_gnt = '0; e_ack = '0; e_err = '0;
    if (mg >= 0) e_gnt[mg] = 1'b1;
    if (act) begin
      e_ack[mg] = sb.ack[0];
      e_err[mg] = sb.err[0] | to_now;
    end
    chk("gnt", gnt, e_gnt);
    if (mg >= 0) chk("gnt_id", gnt_id, mg);
    chk("s_cyc", sb.cyc, act && mb.cyc[mg] && !to_now);
    chk("s_stb", sb.stb, act && mb.stb[mg] && !to_now);
    chk("s_we",  sb.we,  act ? mb.we[mg] : 1'b0);
    chk("s_adr", sb.adr, act ? mb.adr[mg*AW +: AW] : '0);
    chk("s_dat_w", sb.dat_w, act ? mb.dat_w[mg*DW +: DW] : '0);
    chk("s_sel", sb.sel, act ? mb.sel[mg*4 +: 4] : '0);
    chk("s_cti_bte", {sb.cti, sb.bte}, act ? {mb.cti[mg*3 +: 3], mb.bte[mg*2 +: 2]} : '0);
    chk("m_ack", mb.ack, e_ack);
    chk("m_err", mb.err, e_err);
    chk("m_dat_r", mb.dat_r, act ? sb.dat_r : '0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) compare();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [2:0] cti);
    mb.we[i] = we;
    mb.adr[i*AW +: AW] = adr;
    mb.dat_w[i*DW +: DW] = dat;
    mb.sel[i*4 +: 4] = 4'hF;
    mb.cti[i*3 +: 3] = cti;
    mb.bte[i*2 +: 2] = 2'b00;
  endtask

  initial begin
    rstn = 1'b0;
    mb.cyc = '0; mb.stb = '0; mb.we = '0; mb.adr = '0; mb.dat_w = '0;
    mb.sel = '0; mb.cti = '0; mb.bte = '0;
    sb.dat_r = '0; sb.ack = '0; sb.err = '0;

    // Reset with all masters requesting
    mb.cyc = 2'b11;
    repeat (3) step();
    settle();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", sb.cyc, 1'b0);
    chk("rst_m_ack", mb.ack, 2'b00);
    rstn = 1'b1;
    step(); settle();
    chk("rel_gnt", gnt, 2'b01);
    chk("rel_s_cyc", sb.cyc, 1'b1);
    mb.cyc = 2'b00;
    step(); step();

    // Single read by master 1, two wait states
    set_req(1, 1'b0, 32'h0000_1000, 32'h0, 3'b000);
    mb.cyc = 2'b10; mb.stb = 2'b10;
    settle();
    chk("rd_s_cyc_early", sb.cyc, 1'b0);
    step(); settle();
    chk("rd_gnt", gnt, 2'b10);
    chk("rd_s_adr", sb.adr, 32'h0000_1000);
    chk("rd_wait_ack", mb.ack, 2'b00);
    step();
    step();
    sb.ack = 1'b1; sb.dat_r = 32'hDEAD_BEEF;
    settle();
    chk("rd_m_ack", mb.ack, 2'b10);
    chk("rd_m_dat_r", mb.dat_r, 32'hDEAD_BEEF);
    step();
    sb.ack = 1'b0; sb.dat_r = '0; mb.cyc = '0; mb.stb = '0;
    step(); step();

    // Contention: both raise CYC together, one write each
    set_req(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 3'b000);
    set_req(1, 1'b1, 32'h0000_0200, 32'h2222_2222, 3'b000);
    mb.cyc = 2'b11; mb.stb = 2'b11;
    step(); sb.ack = 1'b1; settle();
    chk("ct_gnt0", gnt, 2'b01);
    chk("ct_adr0", sb.adr, 32'h0000_0100);
    chk("ct_ack0", mb.ack, 2'b01);
    step(); sb.ack = 1'b0; mb.cyc = 2'b10; mb.stb = 2'b10; settle();
    chk("ct_drop_s_cyc", sb.cyc, 1'b0);
    step(); settle();
    chk("ct_dead_gnt", gnt, 2'b00);
    step(); sb.ack = 1'b1; settle();
    chk("ct_gnt1", gnt, 2'b10);
    chk("ct_dat1", sb.dat_w, 32'h2222_2222);
    chk("ct_ack1", mb.ack, 2'b10);
    step(); sb.ack = 1'b0; mb.cyc = '0; mb.stb = '0;
    step(); step();

    // Fairness: master 0 drops and re-raises CYC while master 1 waits
    mb.cyc = 2'b01;
    step(); settle();
    chk("fr_gnt0", gnt, 2'b01);
    mb.cyc = 2'b11;
    step();
    mb.cyc = 2'b10;
    step();
    mb.cyc = 2'b11; settle();
    chk("fr_dead", gnt, 2'b00);
    step(); settle();
    chk("fr_gnt1", gnt, 2'b10);
    step();
    mb.cyc = 2'b01;
    step(); settle();
    chk("fr_dead2", gnt, 2'b00);
    step(); settle();
    chk("fr_gnt0_again", gnt, 2'b01);
    mb.cyc = '0;
    step(); step();

    // Burst hold: 4-beat incrementing burst by master 0 while master 1 requests
    set_req(0, 1'b0, 32'h0000_2000, 32'h0, 3'b010);
    set_req(1, 1'b1, 32'h0000_3000, 32'h3333_3333, 3'b000);
    mb.cyc = 2'b01; mb.stb = 2'b01;
    step();
    mb.cyc = 2'b11; mb.stb = 2'b11;
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b0, 32'h0000_2000 + 32'(b * 4), 32'h0, (b == 3) ? 3'b111 : 3'b010);
      sb.ack = 1'b1; sb.dat_r = 32'hA000_0000 + 32'(b);
      settle();
      chk("bu_ack", mb.ack, 2'b01);
      chk("bu_adr", sb.adr, 32'h0000_2000 + 32'(b * 4));
      step();
    end
    sb.ack = 1'b0; sb.dat_r = '0; mb.cyc = 2'b10; mb.stb = 2'b10;
    step(); settle();
    chk("bu_dead", gnt, 2'b00);
    step(); settle();
    chk("bu_gnt1", gnt, 2'b10);
    chk("bu_adr1", sb.adr, 32'h0000_3000);
    mb.cyc = '0; mb.stb = '0;
    step(); step();

    // Slave asserts ACK and ERR together: both forwarded
    mb.cyc = 2'b10; mb.stb = 2'b10;
    step(); sb.ack = 1'b1; sb.err = 1'b1; settle();
    chk("ae_ack", mb.ack, 2'b10);
    chk("ae_err", mb.err, 2'b10);
    step(); sb.ack = 1'b0; sb.err = 1'b0; mb.cyc = '0; mb.stb = '0;
    step(); step();

    // Reset in the middle of a transfer
    mb.cyc = 2'b01; mb.stb = 2'b01;
    step(); settle();
    chk("mr_gnt", gnt, 2'b01);
    rstn = 1'b0;
    step(); settle();
    chk("mr_gnt_rst", gnt, 2'b00);
    chk("mr_s_cyc_rst", sb.cyc, 1'b0);
    rstn = 1'b1; mb.cyc = '0; mb.stb = '0;
    step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers: watchdog fires on the 8th stalled cycle
    mb.cyc = 2'b01; mb.stb = 2'b01;
    step();
    mb.cyc = 2'b11; mb.stb = 2'b11;
    for (int c = 1; c < T; c++) begin
      settle();
      chk("to_no_err", mb.err, 2'b00);
      chk("to_s_cyc", sb.cyc, 1'b1);
      step();
    end
    settle();
    chk("to_err", mb.err, 2'b01);
    chk("to_s_cyc_drop", sb.cyc, 1'b0);
    step(); settle();
    chk("ab_s_cyc", sb.cyc, 1'b0);
    chk("ab_err", mb.err, 2'b00);
    mb.cyc = 2'b10; mb.stb = 2'b10;
    step(); settle();
    chk("ab_idle", gnt, 2'b00);
    step(); settle();
    chk("ab_next", gnt, 2'b10);
    mb.cyc = '0; mb.stb = '0;
    step(); step();
`else
    // Slave stalls: grant held indefinitely
    mb.cyc = 2'b01; mb.stb = 2'b01;
    step();
    mb.cyc = 2'b11; mb.stb = 2'b11;
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("st_gnt", gnt, 2'b01);
      chk("st_s_cyc", sb.cyc, 1'b1);
      step();
    end
    sb.ack = 1'b1; settle();
    chk("st_ack", mb.ack, 2'b01);
    step(); sb.ack = 1'b0; mb.cyc = '0; mb.stb = '0;
    step(); step();
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
